// File: rtl/partial_force_acc_pool.sv
// rtl/partial_force_acc_pool.sv - saturating partial-force accumulator pool with valid/ready drain
module partial_force_acc_pool #(
  parameter int NUM_REGS   = 6,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8,
  parameter int IDX_WIDTH  = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [IDX_WIDTH-1:0]  in_idx,
  input  logic [DATA_WIDTH-1:0] in_fx,
  input  logic [DATA_WIDTH-1:0] in_fy,
  input  logic [DATA_WIDTH-1:0] in_fz,
  input  logic                  rel_valid,
  input  logic [IDX_WIDTH-1:0]  rel_idx,
  output logic                  rel_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic [DATA_WIDTH-1:0] out_fx,
  output logic [DATA_WIDTH-1:0] out_fy,
  output logic [DATA_WIDTH-1:0] out_fz,
  output logic [CNT_WIDTH-1:0]  out_cnt,
  output logic                  out_sat,
  output logic                  in_err
);

  localparam logic [IDX_WIDTH:0] NREG_W = (IDX_WIDTH+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] acc_x [NUM_REGS];
  logic [DATA_WIDTH-1:0] acc_y [NUM_REGS];
  logic [DATA_WIDTH-1:0] acc_z [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt   [NUM_REGS];
  logic                  sat   [NUM_REGS];

  logic                  in_legal, rel_legal, acc_en, rel_fire, rel_take, fwd;
  logic [IDX_WIDTH-1:0]  in_sel, rel_sel;
  logic [DATA_WIDTH-1:0] upd_x, upd_y, upd_z;
  logic                  sx, sy, sz;
  logic [CNT_WIDTH-1:0]  upd_cnt;
  logic                  upd_sat;
  logic [DATA_WIDTH-1:0] ld_x, ld_y, ld_z;
  logic [CNT_WIDTH-1:0]  ld_cnt;
  logic                  ld_sat;

  // Result MSB is the clamp flag; the sum is formed one bit wider to detect overflow.
  function automatic logic [DATA_WIDTH:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      return {1'b1, s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}}};
    return {1'b0, s[DATA_WIDTH-1:0]};
  endfunction

  assign rel_ready = ~out_valid | out_ready;
  assign in_legal  = ({1'b0, in_idx} < NREG_W);
  assign rel_legal = ({1'b0, rel_idx} < NREG_W);
  assign in_sel    = in_legal ? in_idx : '0;
  assign rel_sel   = rel_legal ? rel_idx : '0;
  assign acc_en    = in_valid & in_legal;
  assign rel_fire  = rel_valid & rel_ready;
  assign rel_take  = rel_fire & rel_legal;
  assign fwd       = acc_en & rel_take & (in_sel == rel_sel);

  always_comb begin
    {sx, upd_x} = sat_add(acc_x[in_sel], in_fx);
    {sy, upd_y} = sat_add(acc_y[in_sel], in_fy);
    {sz, upd_z} = sat_add(acc_z[in_sel], in_fz);
    upd_cnt = (cnt[in_sel] == '1) ? cnt[in_sel] : cnt[in_sel] + 1'b1;
    upd_sat = sat[in_sel] | sx | sy | sz;
    // A release hitting the register being accumulated drains the updated value.
    ld_x   = fwd ? upd_x   : acc_x[rel_sel];
    ld_y   = fwd ? upd_y   : acc_y[rel_sel];
    ld_z   = fwd ? upd_z   : acc_z[rel_sel];
    ld_cnt = fwd ? upd_cnt : cnt[rel_sel];
    ld_sat = fwd ? upd_sat : sat[rel_sel];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        acc_x[i] <= '0;
        acc_y[i] <= '0;
        acc_z[i] <= '0;
        cnt[i]   <= '0;
        sat[i]   <= 1'b0;
      end
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_fx    <= '0;
      out_fy    <= '0;
      out_fz    <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
      in_err    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (acc_en && in_sel == IDX_WIDTH'(i)) begin
          acc_x[i] <= upd_x;
          acc_y[i] <= upd_y;
          acc_z[i] <= upd_z;
          cnt[i]   <= upd_cnt;
          sat[i]   <= upd_sat;
        end
        // Clear takes priority so a forwarded contribution is not counted twice.
        if (rel_take && rel_sel == IDX_WIDTH'(i)) begin
          acc_x[i] <= '0;
          acc_y[i] <= '0;
          acc_z[i] <= '0;
          cnt[i]   <= '0;
          sat[i]   <= 1'b0;
        end
      end
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (rel_take) begin
        out_valid <= 1'b1;
        out_idx   <= rel_sel;
        out_fx    <= ld_x;
        out_fy    <= ld_y;
        out_fz    <= ld_z;
        out_cnt   <= ld_cnt;
        out_sat   <= ld_sat;
      end
      in_err <= (in_valid & ~in_legal) | (rel_fire & ~rel_legal);
    end
  end

endmodule

// File: tb/tb_partial_force_acc_pool.sv
// tb/tb_partial_force_acc_pool.sv - directed self-checking bench for partial_force_acc_pool
module tb_partial_force_acc_pool;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_idx = '0;
  logic [31:0] in_fx = '0, in_fy = '0, in_fz = '0;
  logic        rel_valid = 1'b0;
  logic [2:0]  rel_idx = '0;
  logic        rel_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  out_idx;
  logic [31:0] out_fx, out_fy, out_fz;
  logic [3:0]  out_cnt;
  logic        out_sat;
  logic        in_err;

  int checks = 0;
  int failures = 0;

  partial_force_acc_pool #(.NUM_REGS(6), .DATA_WIDTH(32), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_idx(in_idx), .in_fx(in_fx), .in_fy(in_fy), .in_fz(in_fz),
    .rel_valid(rel_valid), .rel_idx(rel_idx), .rel_ready(rel_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_fx(out_fx), .out_fy(out_fy), .out_fz(out_fz),
    .out_cnt(out_cnt), .out_sat(out_sat), .in_err(in_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 0; rel_valid = 0; out_ready = 1;
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
    cyc();
  endtask

  task automatic acc(input logic [2:0] idx, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    in_valid = 1; in_idx = idx; in_fx = x; in_fy = y; in_fz = z;
    cyc();
    in_valid = 0;
  endtask

  task automatic rel(input logic [2:0] idx);
    rel_valid = 1; rel_idx = idx;
    cyc();
    rel_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (rel_ready !== 1'b1) begin failures++; $display("FAIL reset_rel_ready got %b exp 1", rel_ready); end
    checks++; if ({out_fx, out_fy, out_fz, out_cnt, out_sat, in_err, out_idx} !== '0) begin
      failures++; $display("FAIL reset_outputs got %h %h %h %h %b %b exp zeros", out_fx, out_fy, out_fz, out_cnt, out_sat, in_err);
    end
    apply_reset();
  endtask

  task automatic test_accumulate();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_idx = 3'(i % 4); in_fx = 32'h100; in_fy = 32'h100; in_fz = 32'h100;
      cyc();
    end
    in_valid = 0;
    rel(0);
    checks++; if (out_valid !== 1'b1 || out_idx !== 3'd0) begin failures++; $display("FAIL acc_out_valid got %b idx %0d exp 1 idx 0", out_valid, out_idx); end
    checks++; if (out_fx !== 32'h200 || out_fy !== 32'h200 || out_fz !== 32'h200) begin
      failures++; $display("FAIL acc_sum got %h %h %h exp 200", out_fx, out_fy, out_fz);
    end
    checks++; if (out_cnt !== 4'd2 || out_sat !== 1'b0) begin failures++; $display("FAIL acc_cnt got %0d sat %b exp 2 sat 0", out_cnt, out_sat); end
    rel(0);
    checks++; if (out_fx !== 32'h0 || out_cnt !== 4'd0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL acc_cleared got %h cnt %0d v %b exp 0 cnt 0 v 1", out_fx, out_cnt, out_valid);
    end
    cyc();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL acc_drop_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_saturation();
    apply_reset();
    acc(2, 32'h7FFF_FFF0, 32'h8000_0000, 32'h1);
    acc(2, 32'h0000_0100, 32'hFFFF_FFFF, 32'h1);
    rel(2);
    checks++; if (out_fx !== 32'h7FFF_FFFF) begin failures++; $display("FAIL sat_pos got %h exp 7fffffff", out_fx); end
    checks++; if (out_fy !== 32'h8000_0000) begin failures++; $display("FAIL sat_neg got %h exp 80000000", out_fy); end
    checks++; if (out_fz !== 32'h2 || out_sat !== 1'b1 || out_cnt !== 4'd2) begin
      failures++; $display("FAIL sat_flag got fz %h sat %b cnt %0d exp 2 1 2", out_fz, out_sat, out_cnt);
    end
    acc(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    acc(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rel(2);
    checks++; if (out_fx !== 32'hFFFF_FFFE || out_sat !== 1'b0) begin
      failures++; $display("FAIL sat_cleared got %h sat %b exp fffffffe sat 0", out_fx, out_sat);
    end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    acc(1, 32'd5, 32'd5, 32'd5);
    in_valid = 1; in_idx = 1; in_fx = 32'd3; in_fy = 32'd3; in_fz = 32'd3;
    rel_valid = 1; rel_idx = 1;
    cyc();
    in_valid = 0; rel_valid = 0;
    checks++; if (out_fx !== 32'd8 || out_fz !== 32'd8 || out_cnt !== 4'd2) begin
      failures++; $display("FAIL fwd_sum got %0d %0d cnt %0d exp 8 8 cnt 2", out_fx, out_fz, out_cnt);
    end
    rel(1);
    checks++; if (out_fx !== 32'd0 || out_cnt !== 4'd0) begin failures++; $display("FAIL fwd_cleared got %0d cnt %0d exp 0 0", out_fx, out_cnt); end
    acc(1, 32'd9, 32'd0, 32'd0);
    in_valid = 1; in_idx = 4; in_fx = 32'd7; in_fy = 32'd0; in_fz = 32'd0;
    rel_valid = 1; rel_idx = 1;
    cyc();
    in_valid = 0; rel_valid = 0;
    checks++; if (out_fx !== 32'd9 || out_cnt !== 4'd1 || out_idx !== 3'd1) begin
      failures++; $display("FAIL indep_rel got %0d cnt %0d idx %0d exp 9 1 1", out_fx, out_cnt, out_idx);
    end
    rel(4);
    checks++; if (out_fx !== 32'd7 || out_cnt !== 4'd1 || out_idx !== 3'd4) begin
      failures++; $display("FAIL indep_acc got %0d cnt %0d idx %0d exp 7 1 4", out_fx, out_cnt, out_idx);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    acc(0, 32'd10, 32'd0, 32'd0);
    acc(5, 32'd20, 32'd0, 32'd0);
    out_ready = 0;
    rel_valid = 1; rel_idx = 0;
    cyc();
    rel_idx = 5;
    checks++; if (out_valid !== 1'b1 || out_fx !== 32'd10 || rel_ready !== 1'b0) begin
      failures++; $display("FAIL bp_first got v %b fx %0d rdy %b exp 1 10 0", out_valid, out_fx, rel_ready);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_idx = 5; in_fx = 32'd1;
      cyc();
      checks++; if (out_valid !== 1'b1 || out_fx !== 32'd10 || out_idx !== 3'd0 || rel_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold got v %b fx %0d idx %0d rdy %b exp 1 10 0 0", out_valid, out_fx, out_idx, rel_ready);
      end
    end
    in_valid = 0;
    out_ready = 1;
    cyc();
    rel_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_fx !== 32'd23 || out_idx !== 3'd5 || out_cnt !== 4'd4) begin
      failures++; $display("FAIL bp_second got v %b fx %0d idx %0d cnt %0d exp 1 23 5 4", out_valid, out_fx, out_idx, out_cnt);
    end
    cyc();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got %b exp 0", out_valid); end
  endtask

  task automatic test_cnt_sat_and_err();
    apply_reset();
    for (int i = 0; i < 20; i++) acc(3, 32'd1, 32'd0, 32'd0);
    rel(3);
    checks++; if (out_cnt !== 4'd15 || out_fx !== 32'd20) begin
      failures++; $display("FAIL cnt_sat got cnt %0d fx %0d exp 15 20", out_cnt, out_fx);
    end
    acc(0, 32'd4, 32'd0, 32'd0);
    checks++; if (in_err !== 1'b0) begin failures++; $display("FAIL err_idle got %b exp 0", in_err); end
    acc(7, 32'd100, 32'd100, 32'd100);
    checks++; if (in_err !== 1'b1) begin failures++; $display("FAIL err_pulse got %b exp 1", in_err); end
    cyc();
    checks++; if (in_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle got %b exp 0", in_err); end
    rel(6);
    checks++; if (in_err !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL err_rel got err %b v %b exp 1 0", in_err, out_valid);
    end
    rel(0);
    checks++; if (out_fx !== 32'd4 || out_cnt !== 4'd1 || in_err !== 1'b0) begin
      failures++; $display("FAIL err_nochange got %0d cnt %0d err %b exp 4 1 0", out_fx, out_cnt, in_err);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    acc(2, 32'd50, 32'd50, 32'd50);
    acc(3, 32'd60, 32'd60, 32'd60);
    acc(4, 32'd70, 32'd70, 32'd70);
    out_ready = 0;
    rel(3);
    checks++; if (out_valid !== 1'b1 || out_fx !== 32'd60) begin
      failures++; $display("FAIL mid_pending got v %b fx %0d exp 1 60", out_valid, out_fx);
    end
    #2;
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || rel_ready !== 1'b1 || out_fx !== 32'd0) begin
      failures++; $display("FAIL mid_async got v %b rdy %b fx %0d exp 0 1 0", out_valid, rel_ready, out_fx);
    end
    cyc();
    rst_n = 1; out_ready = 1;
    cyc();
    rel(2);
    checks++; if (out_fx !== 32'd0 || out_cnt !== 4'd0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL mid_r2 got %0d cnt %0d v %b exp 0 0 1", out_fx, out_cnt, out_valid);
    end
    rel(4);
    checks++; if (out_fz !== 32'd0 || out_cnt !== 4'd0) begin
      failures++; $display("FAIL mid_r4 got %0d cnt %0d exp 0 0", out_fz, out_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_accumulate();
    test_saturation();
    test_same_cycle();
    test_backpressure();
    test_cnt_sat_and_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/partial_force_acc_pool.md
# partial_force_acc_pool

Parametrised pool of partial-force accumulators for the non-bonded force path. Accepts one fixed-point force (x, y, z) per cycle tagged with a binary register index, accumulates it with saturation into that register, and on request drains any register through a valid/ready output port, clearing it. Generalises the fixed six-slot, one-hot-select accumulator to configurable depth and width, and adds contribution counting, saturation flags, release backpressure and same-cycle accumulate/release forwarding.

## Interface

Parameters:
- NUM_REGS, 6, number of accumulator registers (≥2)
- DATA_WIDTH, 32, width of each signed two's-complement force component
- CNT_WIDTH, 8, width of the per-register contribution counter
- IDX_WIDTH, $clog2(NUM_REGS), index width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  force contribution present this cycle
- in_idx  in  IDX_WIDTH  target register
- in_fx, in_fy, in_fz  in  DATA_WIDTH each  signed force components
- rel_valid  in  1  release request
- rel_idx  in  IDX_WIDTH  register to release
- rel_ready  out  1  release request accepted when rel_valid & rel_ready
- out_valid  out  1  released force valid
- out_ready  in  1  downstream accepts released force
- out_idx  out  IDX_WIDTH  released register index
- out_fx, out_fy, out_fz  out  DATA_WIDTH each  released sums
- out_cnt  out  CNT_WIDTH  number of contributions in released sum
- out_sat  out  1  any component saturated in released sum
- in_err  out  1  one-cycle pulse: in_valid or accepted release with index ≥ NUM_REGS

## Operation

- Per register state: acc_x/y/z (DATA_WIDTH), cnt (CNT_WIDTH), sat (1); all zero after reset.
- Accumulate: in_valid with legal in_idx adds each component; sum formed at DATA_WIDTH+1 bits, clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]; clamping any component sets sat sticky. cnt increments, saturating at all-ones (no wrap).
- Accumulation is always accepted; no input backpressure.
- Release: accepted when rel_valid & rel_ready. rel_ready = ~out_valid | out_ready (single output register, no bubble under continuous ready).
- Accepted release loads the output register from register rel_idx and clears that register (acc, cnt, sat) on the same edge.
- Empty register release is legal: outputs zeros, out_cnt 0, out_sat 0.
- Simultaneous accumulate and accepted release to same index: the incoming force is included (forwarded, with saturation applied) in the released value, out_cnt includes it, and the register is left cleared.
- Simultaneous accumulate and release to different indices: independent.
- Release requested while rel_ready low: no state change; the register keeps accumulating.
- Illegal index (≥ NUM_REGS): operation dropped, no state change, in_err pulses next cycle.
- Output held stable while out_valid & ~out_ready.

## Timing

- Reset: all outputs 0 except rel_ready = 1; takes effect asynchronously, released synchronously to clk. Reset mid-operation discards all accumulators and any pending output.
- Accumulate latency: contribution at edge t visible to a release accepted at edge t (forward) or later.
- Release latency: request accepted at edge t → out_valid high after edge t, for ≥1 cycle until out_ready.
- Throughput: one accumulate and one release per cycle.
- in_err: registered, high for exactly one cycle after the offending edge.

## Test plan

- Reset, then in_valid=1, idx 0..3 round-robin, fx=fy=fz=0x0000_0100, 8 cycles; release idx 0 → out_fx/fy/fz=0x0000_0200, out_cnt=2, out_sat=0; register 0 then releases as zero with cnt 0.
- Accumulate 0x7FFF_FFF0 then 0x0000_0100 into idx 2, release → out_fx=0x7FFF_FFFF, out_sat=1; accumulate −1 into idx 2 twice then release → 0xFFFF_FFFE, sat=0 (cleared).
- Same-cycle: idx 1 holds 5; in_valid idx 1 value 3 with release idx 1 → out_fx=8, out_cnt=2; next release idx 1 → 0, cnt 0.
- Backpressure: out_ready=0, two releases requested → first accepted, rel_ready low, output stable; accumulate into second target continues; raise out_ready → second releases with updated sum, no lost/duplicated output.
- Counter saturation (CNT_WIDTH=4): 20 contributions of 1 to idx 3 → out_cnt=15, out_fx=20; illegal idx 7 (NUM_REGS=6) → in_err one-cycle pulse, no register changed.
- Assert rst_n low with out_valid high and non-zero accumulators → out_valid=0 immediately; after release all registers release as zero.
